// File: rtl/mem_write_checker_if.sv
// Monitored processor write port.
//   memwrite  : write strobe
//   dataadr   : write address (AW bits)
//   writedata : write data (DW bits)
// master drives the port (processor / bench); slave observes it (checker).
interface mem_write_checker_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mem_write_checker.sv
// Memory write checker: watches a processor write port for a run window and
// reports whether the expected write (address/data from a small config table)
// was seen.
// Ports:
//   ph1, reset          : clock, synchronous active-low reset
//   cfg_we/idx/addr/data/chkaddr : expected-result table write port
//   window, start, test_sel, ack : test control
//   wr (slave)          : monitored write port (memwrite, dataadr, writedata)
//   busy, done, pass    : status; pass qualifies done
//   cycles, mismatches  : elapsed cycles, saturating non-matching write count
//   bad_addr, bad_data  : first non-matching write of the test
//   pass_count, fail_count : saturating totals since reset
//
// state | meaning
// IDLE  | waiting for start, table writable
// RUN   | test window active, writes compared every cycle
// DONE  | result valid and held, table writable, ack returns to IDLE
module mem_write_checker #(
  parameter int NUM_TESTS     = 17,
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int CW            = 16,
  parameter int STOP_ON_MATCH = 0,
  localparam int IW           = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [DW-1:0]   cfg_data,
  input  logic            cfg_chkaddr,
  input  logic [CW-1:0]   window,
  input  logic            start,
  input  logic [IW:0]     test_sel,
  input  logic            ack,
  mem_write_checker_if.slave wr,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   cycles,
  output logic [7:0]      mismatches,
  output logic [AW-1:0]   bad_addr,
  output logic [DW-1:0]   bad_data,
  output logic [7:0]      pass_count,
  output logic [7:0]      fail_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [IW:0] NT_SEL = (IW+1)'(NUM_TESTS);

  state_t        state_q, state_d;
  logic [IW:0]   sel_q, sel_d;
  logic [CW-1:0] window_q, window_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic [7:0]    mism_q, mism_d;
  logic          matched_q, matched_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] bad_addr_q, bad_addr_d;
  logic [DW-1:0] bad_data_q, bad_data_d;
  logic [7:0]    pass_count_q, pass_count_d;
  logic [7:0]    fail_count_q, fail_count_d;

  // Expected-result table; deliberately not reset.
  logic [AW-1:0] tbl_addr_q [NUM_TESTS];
  logic [DW-1:0] tbl_data_q [NUM_TESTS];
  logic          tbl_chk_q  [NUM_TESTS];

  logic          tbl_we;
  logic          sel_ok;
  logic [IW-1:0] sel_idx;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          exp_chk;
  logic          hit;
  logic          matched_now;
  logic [CW-1:0] cycles_inc;
  logic          start_bad;

  assign tbl_we = cfg_we && (state_q != S_RUN) && ({1'b0, cfg_idx} < NT_SEL);

  always_ff @(posedge ph1) begin
    if (tbl_we) begin
      tbl_addr_q[cfg_idx] <= cfg_addr;
      tbl_data_q[cfg_idx] <= cfg_data;
      tbl_chk_q[cfg_idx]  <= cfg_chkaddr;
    end
  end

  // sel_q can hold an out-of-range selector after a rejected start; steer
  // the lookup to entry 0 then so the read index always stays in bounds.
  assign sel_ok   = (sel_q < NT_SEL);
  assign sel_idx  = sel_ok ? sel_q[IW-1:0] : '0;
  assign exp_addr = tbl_addr_q[sel_idx];
  assign exp_data = tbl_data_q[sel_idx];
  assign exp_chk  = tbl_chk_q[sel_idx];

  // memwrite gates the compare first so address/data are don't-care when idle.
  assign hit = wr.memwrite && (wr.writedata == exp_data) &&
               (!exp_chk || (wr.dataadr == exp_addr));
  assign matched_now = matched_q | hit;
  assign cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + CW'(1);
  assign start_bad   = (test_sel >= NT_SEL) || (window == '0);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    window_d     = window_q;
    cycles_d     = cycles_q;
    mism_d       = mism_q;
    matched_d    = matched_q;
    pass_d       = pass_q;
    bad_addr_d   = bad_addr_q;
    bad_data_d   = bad_data_q;
    pass_count_d = pass_count_q;
    fail_count_d = fail_count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sel_d      = test_sel;
          window_d   = window;
          cycles_d   = '0;
          mism_d     = '0;
          matched_d  = 1'b0;
          pass_d     = 1'b0;
          bad_addr_d = '0;
          bad_data_d = '0;
          if (start_bad) begin
            state_d      = S_DONE;
            fail_count_d = (fail_count_q == 8'hFF) ? fail_count_q : fail_count_q + 8'd1;
          end else begin
            state_d = S_RUN;
          end
        end else if ((state_q == S_DONE) && ack) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        cycles_d  = cycles_inc;
        matched_d = matched_now;
        if (wr.memwrite && !hit) begin
          if (mism_q == 8'd0) begin
            bad_addr_d = wr.dataadr;
            bad_data_d = wr.writedata;
          end
          if (mism_q != 8'hFF) mism_d = mism_q + 8'd1;
        end
        // Terminal compare uses this cycle's count, so a write on the last
        // cycle is still judged before the result is frozen.
        if ((cycles_inc == window_q) || ((STOP_ON_MATCH != 0) && hit)) begin
          state_d = S_DONE;
          pass_d  = matched_now;
          if (matched_now)
            pass_count_d = (pass_count_q == 8'hFF) ? pass_count_q : pass_count_q + 8'd1;
          else
            fail_count_d = (fail_count_q == 8'hFF) ? fail_count_q : fail_count_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ph1) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      window_q     <= '0;
      cycles_q     <= '0;
      mism_q       <= '0;
      matched_q    <= 1'b0;
      pass_q       <= 1'b0;
      bad_addr_q   <= '0;
      bad_data_q   <= '0;
      pass_count_q <= '0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      window_q     <= window_d;
      cycles_q     <= cycles_d;
      mism_q       <= mism_d;
      matched_q    <= matched_d;
      pass_q       <= pass_d;
      bad_addr_q   <= bad_addr_d;
      bad_data_q   <= bad_data_d;
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign cycles     = cycles_q;
  assign mismatches = mism_q;
  assign bad_addr   = bad_addr_q;
  assign bad_data   = bad_data_q;
  assign pass_count = pass_count_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: two instances (run full window / stop on
// match) see identical stimulus; a reference model computes each test's
// result up front and a monitor compares whenever done rises.
module tb_mem_write_checker;
  localparam int NT   = 17;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 10;
  localparam int IW   = $clog2(NT);
  localparam int MAXC = 400;

  typedef struct {
    logic          pass;
    int            cycles;
    int            mism;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    int            pc;
    int            fc;
  } exp_t;

  logic ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  logic          reset;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_chkaddr;
  logic [CW-1:0] window;
  logic          start;
  logic [IW:0]   test_sel;
  logic          ack;
  logic          mw;
  logic [AW-1:0] ad;
  logic [DW-1:0] wd;

  logic          busy [2];
  logic          done [2];
  logic          pass [2];
  logic [CW-1:0] cycles [2];
  logic [7:0]    mism [2];
  logic [AW-1:0] bad_addr [2];
  logic [DW-1:0] bad_data [2];
  logic [7:0]    pc [2];
  logic [7:0]    fc [2];

  mem_write_checker_if #(.AW(AW), .DW(DW)) bus0 ();
  mem_write_checker_if #(.AW(AW), .DW(DW)) bus1 ();
  assign bus0.memwrite = mw;
  assign bus0.dataadr = ad;
  assign bus0.writedata = wd;
  assign bus1.memwrite = mw;
  assign bus1.dataadr = ad;
  assign bus1.writedata = wd;

  mem_write_checker #(.NUM_TESTS(NT), .AW(AW), .DW(DW), .CW(CW), .STOP_ON_MATCH(0)) u_dut0 (
    .ph1(ph1), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_chkaddr(cfg_chkaddr), .window(window), .start(start),
    .test_sel(test_sel), .ack(ack), .wr(bus0), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .cycles(cycles[0]), .mismatches(mism[0]), .bad_addr(bad_addr[0]),
    .bad_data(bad_data[0]), .pass_count(pc[0]), .fail_count(fc[0]));

  mem_write_checker #(.NUM_TESTS(NT), .AW(AW), .DW(DW), .CW(CW), .STOP_ON_MATCH(1)) u_dut1 (
    .ph1(ph1), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_chkaddr(cfg_chkaddr), .window(window), .start(start),
    .test_sel(test_sel), .ack(ack), .wr(bus1), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .cycles(cycles[1]), .mismatches(mism[1]), .bad_addr(bad_addr[1]),
    .bad_data(bad_data[1]), .pass_count(pc[1]), .fail_count(fc[1]));

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  logic [AW-1:0] t_addr [NT];
  logic [DW-1:0] t_data [NT];
  logic          t_chk  [NT];
  logic          p_mw [MAXC];
  logic [AW-1:0] p_a  [MAXC];
  logic [DW-1:0] p_d  [MAXC];
  int            m_pc [2];
  int            m_fc [2];
  exp_t          sbq [2][$];
  exp_t          last [2];
  logic          done_prev [2];
  bit            ack_with_start = 0;

  task automatic chk(string name, int i, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, i, act, exp);
    end
  endtask

  function automatic exp_t model(int sel, int win, int stop);
    exp_t e;
    bit   hit;
    bit   seen_bad = 0;
    e.pass = 0; e.cycles = 0; e.mism = 0; e.ba = '0; e.bd = '0;
    if (sel < NT && win > 0) begin
      for (int c = 1; c <= win; c++) begin
        e.cycles = c;
        if (p_mw[c]) begin
          hit = (p_d[c] == t_data[sel]) && (!t_chk[sel] || p_a[c] == t_addr[sel]);
          if (hit) e.pass = 1;
          else begin
            if (!seen_bad) begin e.ba = p_a[c]; e.bd = p_d[c]; seen_bad = 1; end
            e.mism = (e.mism < 255) ? e.mism + 1 : 255;
          end
          if (hit && stop != 0) break;
        end
      end
    end
    if (e.pass) m_pc[stop] = (m_pc[stop] < 255) ? m_pc[stop] + 1 : 255;
    else        m_fc[stop] = (m_fc[stop] < 255) ? m_fc[stop] + 1 : 255;
    e.pc = m_pc[stop];
    e.fc = m_fc[stop];
    return e;
  endfunction

  // monitor: compare when a result is presented
  always @(negedge ph1) begin
    for (int i = 0; i < 2; i++) begin
      if (reset && done[i] && !done_prev[i]) begin
        if (sbq[i].size() == 0) begin
          chk("unexpected_done", i, 1, 0);
        end else begin
          exp_t e;
          e = sbq[i].pop_front();
          chk("pass", i, pass[i], e.pass);
          chk("cycles", i, cycles[i], e.cycles);
          chk("mismatches", i, mism[i], e.mism);
          chk("bad_addr", i, bad_addr[i], e.ba);
          chk("bad_data", i, bad_data[i], e.bd);
          chk("pass_count", i, pc[i], e.pc);
          chk("fail_count", i, fc[i], e.fc);
          chk("busy_in_done", i, busy[i], 0);
        end
      end
      done_prev[i] = done[i];
    end
  end

  task automatic chk_zero(string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_busy"}, i, busy[i], 0);
      chk({tag, "_done"}, i, done[i], 0);
      chk({tag, "_pass"}, i, pass[i], 0);
      chk({tag, "_cycles"}, i, cycles[i], 0);
      chk({tag, "_mism"}, i, mism[i], 0);
      chk({tag, "_bad_addr"}, i, bad_addr[i], 0);
      chk({tag, "_bad_data"}, i, bad_data[i], 0);
      chk({tag, "_pass_count"}, i, pc[i], 0);
      chk({tag, "_fail_count"}, i, fc[i], 0);
    end
  endtask

  task automatic cfg_write(int idx, logic [AW-1:0] a, logic [DW-1:0] d, logic c);
    cfg_we = 1; cfg_idx = idx[IW-1:0]; cfg_addr = a; cfg_data = d; cfg_chkaddr = c;
    @(posedge ph1); #1;
    cfg_we = 0;
    if (idx < NT) begin t_addr[idx] = a; t_data[idx] = d; t_chk[idx] = c; end
  endtask

  task automatic load_table();
    for (int k = 0; k < NT; k++)
      cfg_write(k, AW'($urandom_range(0, 15) * 4), DW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
  endtask

  task automatic clear_plan();
    for (int c = 0; c < MAXC; c++) begin
      p_mw[c] = 0; p_a[c] = $urandom; p_d[c] = $urandom;
    end
  endtask

  task automatic gen_plan(int sel, int win);
    clear_plan();
    for (int c = 1; c <= win + 2; c++) begin
      int r = $urandom_range(0, 9);
      if (sel < NT && r <= 1) begin
        p_mw[c] = 1; p_a[c] = t_addr[sel]; p_d[c] = t_data[sel];
      end else if (sel < NT && r == 2) begin
        p_mw[c] = 1; p_a[c] = AW'($urandom_range(0, 15) * 4); p_d[c] = t_data[sel];
      end else if (r <= 5) begin
        p_mw[c] = 1; p_a[c] = AW'($urandom_range(0, 15) * 4); p_d[c] = DW'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic run_test(int sel, int win, bit keep_done);
    exp_t e0, e1;
    bit   valid = (sel < NT) && (win > 0);
    e0 = model(sel, win, 0);
    e1 = model(sel, win, 1);
    sbq[0].push_back(e0); sbq[1].push_back(e1);
    last[0] = e0; last[1] = e1;
    test_sel = sel[IW:0]; window = win[CW-1:0];
    start = 1; ack = ack_with_start;
    @(posedge ph1); #1;
    start = 0; ack = 0; ack_with_start = 0;
    for (int c = 1; c <= win + 2; c++) begin
      if (c == 1) begin
        for (int i = 0; i < 2; i++) begin
          chk("first_busy", i, busy[i], valid);
          chk("first_done", i, done[i], !valid);
        end
      end
      mw = p_mw[c]; ad = p_a[c]; wd = p_d[c];
      if (c <= e1.cycles && $urandom_range(0, 3) == 0) begin
        cfg_we = 1; cfg_idx = IW'($urandom_range(0, NT - 1));
        cfg_addr = $urandom; cfg_data = $urandom; cfg_chkaddr = 1'($urandom_range(0, 1));
      end
      @(posedge ph1); #1;
      cfg_we = 0;
    end
    mw = 0; ad = $urandom; wd = $urandom;
    for (int i = 0; i < 2; i++) begin
      chk("result_seen", i, sbq[i].size(), 0);
      sbq[i].delete();
      chk("hold_done", i, done[i], 1);
      chk("hold_pass", i, pass[i], last[i].pass);
      chk("hold_cycles", i, cycles[i], last[i].cycles);
      chk("hold_mism", i, mism[i], last[i].mism);
    end
    if (keep_done) begin
      ack_with_start = 1;
    end else begin
      ack = 1;
      @(posedge ph1); #1;
      ack = 0;
      for (int i = 0; i < 2; i++) begin
        chk("ack_done", i, done[i], 0);
        chk("ack_busy", i, busy[i], 0);
        chk("ack_cycles_kept", i, cycles[i], last[i].cycles);
      end
    end
  endtask

  initial begin
    reset = 0; cfg_we = 0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0; cfg_chkaddr = 0;
    window = '0; start = 0; test_sel = '0; ack = 0; mw = 0; ad = '0; wd = '0;
    m_pc[0] = 0; m_pc[1] = 0; m_fc[0] = 0; m_fc[1] = 0;
    done_prev[0] = 0; done_prev[1] = 0;
    repeat (3) @(posedge ph1);
    #1;
    chk_zero("reset");
    reset = 1;
    load_table();

    // abort a run at cycle 30 with reset
    cfg_write(0, 32'h14, 32'd21, 1);
    test_sel = '0; window = 10'd100; start = 1;
    @(posedge ph1); #1;
    start = 0;
    for (int c = 1; c <= 30; c++) begin
      mw = (c % 3 == 0); ad = 32'h100; wd = 32'd5;
      @(posedge ph1); #1;
    end
    mw = 0;
    for (int i = 0; i < 2; i++) chk("mid_run_busy", i, busy[i], 1);
    reset = 0;
    @(posedge ph1); #1;
    reset = 1;
    chk_zero("abort");
    m_pc[0] = 0; m_pc[1] = 0; m_fc[0] = 0; m_fc[1] = 0;

    // table must be rewritten after reset
    load_table();

    cfg_write(0, 32'h14, 32'd21, 1);
    clear_plan(); p_mw[40] = 1; p_a[40] = 32'h14; p_d[40] = 32'd21;
    run_test(0, 100, 0);

    cfg_write(1, 32'h204, 32'd7, 1);
    clear_plan();
    p_mw[3] = 1; p_a[3] = 32'h200; p_d[3] = 32'd7;
    p_mw[8] = 1; p_a[8] = 32'h204; p_d[8] = 32'd9;
    run_test(1, 20, 0);

    cfg_write(2, 32'h123, 32'd479001600, 0);
    clear_plan(); p_mw[5] = 1; p_a[5] = 32'h7fc; p_d[5] = 32'd479001600;
    run_test(2, 50, 0);

    cfg_write(3, 32'h40, 32'h55, 1);
    clear_plan(); p_mw[10] = 1; p_a[10] = 32'h40; p_d[10] = 32'h55;
    run_test(3, 10, 0);
    clear_plan(); p_mw[11] = 1; p_a[11] = 32'h40; p_d[11] = 32'h55;
    run_test(3, 10, 0);

    clear_plan();
    run_test(NT, 10, 0);
    run_test(4, 0, 0);

    // start beats ack in DONE
    gen_plan(5, 12);
    run_test(5, 12, 1);
    gen_plan(6, 15);
    run_test(6, 15, 0);

    // mismatch counter saturation
    cfg_write(7, 32'h80, 32'h99, 1);
    clear_plan();
    for (int c = 1; c <= 302; c++) begin p_mw[c] = 1; p_a[c] = 32'h80; p_d[c] = DW'(c); end
    run_test(7, 300, 0);

    // out-of-range table writes are dropped
    cfg_write(NT, 32'h0, 32'h0, 0);
    cfg_write(31, 32'h4, 32'h1, 0);

    for (int t = 0; t < 40; t++) begin
      int sel = $urandom_range(0, NT);
      int win = $urandom_range(0, 40);
      if ($urandom_range(0, 3) == 0)
        cfg_write($urandom_range(0, NT - 1), AW'($urandom_range(0, 15) * 4),
                  DW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      gen_plan(sel, win);
      run_test(sel, win, 0);
    end

    // fail counter saturation
    clear_plan();
    for (int t = 0; t < 260; t++) run_test(NT, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
